// File: rtl/prox_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prox_sample_ctrl
// Description : Proximity-sensor sample sequencer. A free-running divider
//               produces a sample tick. Each tick starts two byte reads over a
//               req/ack bus handshake: REG_LO first, then REG_HI. The two bytes
//               are assembled into a 16-bit word. The word is published with a
//               one-cycle dat_valid strobe. Bus errors and timeouts are counted
//               and, once enough happen back to back, raise sensor_fault.
//
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               enable           - sampling enable (level)
//               rd_req, rd_addr  - read request and register address to bus
//               rd_ack, rd_err   - one-cycle completion / failure pulses
//               rd_data          - read byte, valid with rd_ack
//               prox_dat         - latest published proximity word
//               dat_valid        - one-cycle strobe, prox_dat updated
//               sensor_fault     - FAULT_THRESH consecutive failed samples
//               err_cnt          - saturating count of failed samples
//
// Build macro : PROX_AVG_EN - publish the mean of the last four assembled
//               words instead of the raw word (adds one cycle of latency).
//
// Revision    : 1.0 - initial release
// ============================================================================
module prox_sample_ctrl #(
    parameter int unsigned CLK_FREQ     = 12000000,
    parameter int unsigned SAMPLE_HZ    = 100,
    parameter int unsigned TIMEOUT_CYC  = 4095,
    parameter logic [7:0]  REG_LO       = 8'h9C,
    parameter logic [7:0]  REG_HI       = 8'h9D,
    parameter int unsigned FAULT_THRESH = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        rd_req,
    output logic [7:0]  rd_addr,
    input  logic        rd_ack,
    input  logic        rd_err,
    input  logic [7:0]  rd_data,
    output logic [15:0] prox_dat,
    output logic        dat_valid,
    output logic        sensor_fault,
    output logic [7:0]  err_cnt
);

    localparam int unsigned c_DIV    = CLK_FREQ / SAMPLE_HZ;
    localparam int unsigned c_TICK_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int unsigned c_TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(c_DIV - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]          c_FAULT_TH  = 8'(FAULT_THRESH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_REQ_LO    = 3'd2,
        S_LO_GAP    = 3'd3,
        S_REQ_HI    = 3'd4,
        S_ACCUM     = 3'd5,
        S_PUBLISH   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [7:0]          r_lo;
    logic [7:0]          r_consec;
    logic                r_discard;
    logic [15:0]         r_prox_dat;
    logic                r_fault;
    logic [7:0]          r_err_cnt;

    logic       w_tick;
    logic       w_in_req;
    logic       w_in_sample;
    logic       w_resp;
    logic       w_ok;
    logic       w_fail;
    logic       w_abandon;
    logic       w_count_fail;
    logic       w_enter_pub;
    logic [7:0] w_consec_inc;

    // ------------------------------------------------------------------
    // Sample tick divider: free-runs only while enabled, parked at 0 otherwise
    // ------------------------------------------------------------------
    assign w_tick = enable && (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (!enable || (r_tick_cnt == c_TICK_LAST)) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshake qualification. Responses only count while a request is up;
    // an err pulse wins over a coincident ack.
    // ------------------------------------------------------------------
    assign w_in_req    = (r_state == S_REQ_LO) || (r_state == S_REQ_HI);
    assign w_in_sample = w_in_req || (r_state == S_LO_GAP);
    assign w_resp      = w_in_req && (rd_ack || rd_err);
    assign w_ok        = w_in_req && rd_ack && !rd_err;
    assign w_fail      = w_in_req && (rd_err || (!rd_ack && (r_to_cnt == c_TO_LAST)));

    // A sample is abandoned once enable has been seen low at any point
    // during the read; the bus transaction itself still runs to completion.
    assign w_abandon    = r_discard || !enable;
    assign w_count_fail = w_fail && !w_abandon;
    assign w_consec_inc = (r_consec == 8'hFF) ? r_consec : (r_consec + 8'd1);
    assign w_enter_pub  = (r_state != S_PUBLISH) && (w_next_state == S_PUBLISH);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        rd_req       = 1'b0;
        rd_addr      = 8'h00;
        dat_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next_state = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (!enable)     w_next_state = S_IDLE;
                else if (w_tick) w_next_state = S_REQ_LO;
            end
            S_REQ_LO: begin
                rd_req  = 1'b1;
                rd_addr = REG_LO;
                if (w_fail)    w_next_state = w_abandon ? S_IDLE : S_WAIT_TICK;
                else if (w_ok) w_next_state = w_abandon ? S_IDLE : S_LO_GAP;
            end
            S_LO_GAP: begin
                // rd_req is low for exactly this one cycle between bytes
                w_next_state = w_abandon ? S_IDLE : S_REQ_HI;
            end
            S_REQ_HI: begin
                rd_req  = 1'b1;
                rd_addr = REG_HI;
                if (w_fail) begin
                    w_next_state = w_abandon ? S_IDLE : S_WAIT_TICK;
                end else if (w_ok) begin
`ifdef PROX_AVG_EN
                    w_next_state = w_abandon ? S_IDLE : S_ACCUM;
`else
                    w_next_state = w_abandon ? S_IDLE : S_PUBLISH;
`endif
                end
            end
            S_ACCUM: begin
                w_next_state = S_PUBLISH;
            end
            S_PUBLISH: begin
                dat_valid    = 1'b1;
                w_next_state = enable ? S_WAIT_TICK : S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-request timeout counter; idles at 0 outside the REQ states so
    // every REQ state entry starts from a fresh count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_in_req && !w_resp && (r_to_cnt != c_TO_LAST)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Low-byte latch, disable tracking, error accounting
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo      <= 8'h00;
            r_discard <= 1'b0;
            r_err_cnt <= 8'h00;
            r_consec  <= 8'h00;
            r_fault   <= 1'b0;
        end else begin
            if ((r_state == S_REQ_LO) && w_ok) begin
                r_lo <= rd_data;
            end

            r_discard <= w_in_sample ? (r_discard || !enable) : 1'b0;

            if (w_count_fail) begin
                if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                r_consec <= w_consec_inc;
                if (w_consec_inc >= c_FAULT_TH) r_fault <= 1'b1;
            end else if (w_enter_pub) begin
                r_consec <= 8'h00;
                r_fault  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Published word
    // ------------------------------------------------------------------
`ifdef PROX_AVG_EN
    // r_buf[0] is the newest word. The first good sample after reset
    // preloads every entry so the average starts at that value.
    logic [15:0] r_word;
    logic [15:0] r_buf [4];
    logic        r_filled;
    logic [17:0] w_sum;
    logic [15:0] w_avg;

    assign w_sum = {2'b00, r_word} + {2'b00, r_buf[0]}
                 + {2'b00, r_buf[1]} + {2'b00, r_buf[2]};
    assign w_avg = r_filled ? w_sum[17:2] : r_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word     <= 16'h0000;
            r_buf[0]   <= 16'h0000;
            r_buf[1]   <= 16'h0000;
            r_buf[2]   <= 16'h0000;
            r_buf[3]   <= 16'h0000;
            r_filled   <= 1'b0;
            r_prox_dat <= 16'h0000;
        end else begin
            if ((r_state == S_REQ_HI) && w_ok) begin
                r_word <= {rd_data, r_lo};
            end
            if (r_state == S_ACCUM) begin
                if (r_filled) begin
                    r_buf[3] <= r_buf[2];
                    r_buf[2] <= r_buf[1];
                    r_buf[1] <= r_buf[0];
                end else begin
                    r_buf[3] <= r_word;
                    r_buf[2] <= r_word;
                    r_buf[1] <= r_word;
                end
                r_buf[0]   <= r_word;
                r_filled   <= 1'b1;
                r_prox_dat <= w_avg;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prox_dat <= 16'h0000;
        end else if (w_enter_pub) begin
            r_prox_dat <= {rd_data, r_lo};
        end
    end
`endif

    assign prox_dat     = r_prox_dat;
    assign sensor_fault = r_fault;
    assign err_cnt      = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prox_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prox_sample_ctrl
// Description : Self-checking bench for prox_sample_ctrl. The bench acts as
//               the bus master, serving each request from a vector table.
//               Expected words are queued when the high byte is acked.
//               Published words are captured when dat_valid pulses and are
//               then matched against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prox_sample_ctrl;

    localparam int DIV = 100;
    localparam int TO  = 200;
    localparam logic [7:0] A_LO = 8'h9C;
    localparam logic [7:0] A_HI = 8'h9D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        rd_ack = 1'b0;
    logic        rd_err = 1'b0;
    logic [7:0]  rd_data = 8'h00;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic [15:0] prox_dat;
    logic        dat_valid;
    logic        sensor_fault;
    logic [7:0]  err_cnt;

    prox_sample_ctrl #(
        .CLK_FREQ    (100),
        .SAMPLE_HZ   (1),
        .TIMEOUT_CYC (TO),
        .REG_LO      (A_LO),
        .REG_HI      (A_HI),
        .FAULT_THRESH(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_err      (rd_err),
        .rd_data     (rd_data),
        .prox_dat    (prox_dat),
        .dat_valid   (dat_valid),
        .sensor_fault(sensor_fault),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = ack, 1 = err, 2 = ack+err together, 3 = no response
    typedef struct {
        int         lo_kind;
        int         lo_dly;
        int         hi_kind;
        int         hi_dly;
        logic [7:0] lo;
        logic [7:0] hi;
        int         exp_err;
        logic       exp_fault;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] dat;
    } obs_t;

    obs_t        obs_q[$];
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        if (dat_valid) obs_q.push_back('{cyc, prox_dat});
    end

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_prox = 16'h0000;
    int          lo_req_cyc = 0;
    int          last_dv_cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!rd_req && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("req_arrives", 32'(rd_req), 1);
    endtask

    // Called at the negedge where rd_req is first seen high.
    task automatic serve_byte(input logic [7:0] addr, input int kind, input int dly,
                              input logic [7:0] data, input string tag);
        int n;
        chk({tag, "_addr"}, 32'(rd_addr), 32'(addr));
        if (kind == 3) begin
            n = 0;
            while (rd_req && n < TO + 10) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_timeout_len"}, n, TO);
        end else begin
            repeat (dly) @(negedge clk);
            chk({tag, "_req_held"}, 32'(rd_req), 1);
            rd_ack  = (kind != 1);
            rd_err  = (kind != 0);
            rd_data = data;
            @(negedge clk);
            rd_ack  = 1'b0;
            rd_err  = 1'b0;
            rd_data = 8'h00;
            chk({tag, "_req_drop"}, 32'(rd_req), 0);
        end
    endtask

    task automatic check_sb(input int lat_exp);
        obs_t        o;
        logic [15:0] e;
        chk("dv_count", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk("prox_dat_sb", 32'(o.dat), 32'(e));
            if (lat_exp >= 0) chk("latency", o.cyc - lo_req_cyc, lat_exp);
            last_dv_cyc = o.cyc;
        end
        exp_q.delete();
        obs_q.delete();
        chk("prox_hold", 32'(prox_dat), 32'(model_prox));
    endtask

    task automatic do_sample(input vec_t v);
        int lat_exp;
        lat_exp = -1;
        wait_req();
        lo_req_cyc = cyc;
        serve_byte(A_LO, v.lo_kind, v.lo_dly, v.lo, "lo");
        if (v.lo_kind == 0) begin
            @(negedge clk);
            chk("gap_one_cycle", 32'(rd_req), 1);
            serve_byte(A_HI, v.hi_kind, v.hi_dly, v.hi, "hi");
            if (v.hi_kind == 0) begin
                exp_q.push_back({v.hi, v.lo});
                model_prox = {v.hi, v.lo};
                lat_exp    = v.lo_dly + v.hi_dly + 3;
            end
        end
        repeat (3) @(negedge clk);
        check_sb(lat_exp);
    endtask

    // Counts negedges from now until rd_req rises (first tick after enable).
    task automatic enable_and_measure(input string tag);
        int n;
        @(negedge clk);
        enable = 1'b1;
        n = 0;
        while (!rd_req && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, DIV);
    endtask

    vec_t vecs[10];
    int   dv_at[10];

    initial begin
        int   n;
        int   exp_err;
        vec_t v;

        vecs[0] = '{0, 3, 0, 3, 8'h34, 8'h12, 0, 1'b0};
        vecs[1] = '{0, 3, 0, 3, 8'h34, 8'h12, 0, 1'b0};
        vecs[2] = '{0, 3, 1, 2, 8'h11, 8'h22, 1, 1'b0};
        vecs[3] = '{0, 2, 0, 4, 8'h78, 8'h56, 1, 1'b0};
        vecs[4] = '{3, 0, 0, 0, 8'h00, 8'h00, 2, 1'b0};
        vecs[5] = '{0, 1, 3, 0, 8'h01, 8'h02, 3, 1'b0};
        vecs[6] = '{3, 0, 0, 0, 8'h00, 8'h00, 4, 1'b1};
        vecs[7] = '{0, 5, 0, 1, 8'h00, 8'hFF, 4, 1'b0};
        vecs[8] = '{2, 2, 0, 0, 8'h55, 8'h66, 5, 1'b0};
        vecs[9] = '{0, 0, 0, 0, 8'hAB, 8'hCD, 5, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rd_req", 32'(rd_req), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_prox_dat", 32'(prox_dat), 0);
        chk("rst_dat_valid", 32'(dat_valid), 0);
        chk("rst_fault", 32'(sensor_fault), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        enable_and_measure("first_tick");

        for (int i = 0; i < 10; i++) begin
            do_sample(vecs[i]);
            dv_at[i] = last_dv_cyc;
            chk("err_cnt", 32'(err_cnt), vecs[i].exp_err);
            chk("sensor_fault", 32'(sensor_fault), 32'(vecs[i].exp_fault));
            if (i == 1) chk("tick_period", dv_at[1] - dv_at[0], DIV);
        end
        exp_err = 5;

        // Disable while low-byte read outstanding, ack arrives later
        wait_req();
        enable = 1'b0;
        repeat (5) @(negedge clk);
        chk("disc_req_held", 32'(rd_req), 1);
        rd_ack  = 1'b1;
        rd_data = 8'h77;
        @(negedge clk);
        rd_ack  = 1'b0;
        rd_data = 8'h00;
        chk("disc_req_drop", 32'(rd_req), 0);
        n = 0;
        repeat (150) begin
            @(negedge clk);
            if (rd_req) n++;
        end
        chk("disc_idle_no_req", n, 0);
        chk("disc_no_valid", obs_q.size(), 0);
        chk("disc_err_cnt", 32'(err_cnt), exp_err);
        chk("disc_prox_hold", 32'(prox_dat), 32'(model_prox));

        // Re-enable: divider restarts from 0
        enable_and_measure("reenable_tick");
        v = '{0, 2, 0, 2, 8'hBC, 8'h9A, 0, 1'b0};
        do_sample(v);

        // Disable while read outstanding, bus errors: not counted
        wait_req();
        enable = 1'b0;
        serve_byte(A_LO, 1, 2, 8'h00, "disc_err");
        repeat (3) @(negedge clk);
        chk("disc_err_cnt2", 32'(err_cnt), exp_err);
        chk("disc_err_no_valid", obs_q.size(), 0);
        enable_and_measure("reenable_tick2");

        // Low-byte ack held off beyond one tick period: tick dropped
        v = '{0, 150, 0, 3, 8'h22, 8'h11, 0, 1'b0};
        do_sample(v);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_req) n++;
        end
        chk("no_queued_tick", n, 0);

        // Simultaneous ack+err on high byte counts as an error
        v = '{0, 1, 2, 1, 8'h44, 8'h33, 0, 1'b0};
        do_sample(v);
        exp_err++;
        chk("ackerr_err_cnt", 32'(err_cnt), exp_err);
        chk("ackerr_fault", 32'(sensor_fault), 0);

        // Reset acts without a clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_err_cnt", 32'(err_cnt), 0);
        chk("async_rst_prox", 32'(prox_dat), 0);
        chk("async_rst_req", 32'(rd_req), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
